// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB of 2-bit saturating counters for fetch-side direction/target prediction,
// trained from execute-stage resolved outcomes; also flags mispredicts and counts them.
module branch_predictor #(
   parameter int IDX_W = 6,
   parameter int TAG_W = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_if_pc,
   output logic        o_pred_taken,
   output logic [31:0] o_pred_target,
   input  logic        i_upd_valid,
   input  logic [31:0] i_upd_pc,
   input  logic        i_upd_taken,
   input  logic [31:0] i_upd_target,
   input  logic        i_upd_pred_taken,
   input  logic [31:0] i_upd_pred_tgt,
   output logic        o_mispredict,
   output logic [31:0] o_redirect_pc,
   output logic [31:0] o_mispred_cnt
);

   localparam int ENTRIES = 2 ** IDX_W;

   logic              r_valid  [ENTRIES];
   logic [TAG_W-1:0]  r_tag    [ENTRIES];
   logic [29:0]       r_target [ENTRIES];
   logic [1:0]        r_ctr    [ENTRIES];
   logic [31:0]       r_mispred_cnt;

   logic [IDX_W-1:0]  w_if_idx;
   logic [TAG_W-1:0]  w_if_tag;
   logic              w_if_hit;
   logic [IDX_W-1:0]  w_upd_idx;
   logic [TAG_W-1:0]  w_upd_tag;
   logic              w_upd_hit;
   logic              w_unused;

   assign w_if_idx  = i_if_pc[IDX_W+1:2];
   assign w_if_tag  = i_if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign w_upd_idx = i_upd_pc[IDX_W+1:2];
   assign w_upd_tag = i_upd_pc[IDX_W+TAG_W+1:IDX_W+2];

   // Word-aligned PCs leave low bits (and high bits when IDX_W+TAG_W < 30) unread.
   assign w_unused = ^{i_if_pc, i_upd_pc, i_upd_target[1:0]};

   // Lookup reads pre-update contents, giving read-before-write on index collision.
   assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
   assign o_pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
   assign o_pred_target = o_pred_taken ? {r_target[w_if_idx], 2'b00} : i_if_pc + 32'd4;

   assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

   assign o_mispredict = i_upd_valid &&
                         ((i_upd_taken != i_upd_pred_taken) ||
                          (i_upd_taken && i_upd_pred_taken && (i_upd_target != i_upd_pred_tgt)));
   assign o_redirect_pc = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;
   assign o_mispred_cnt = r_mispred_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_ctr[i]    <= 2'b01;
         end
      end else if (i_upd_valid) begin
         if (w_upd_hit) begin
            if (i_upd_taken) begin
               if (r_ctr[w_upd_idx] != 2'b11) r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] + 2'b01;
               r_target[w_upd_idx] <= i_upd_target[31:2];
            end else if (r_ctr[w_upd_idx] != 2'b00) begin
               r_ctr[w_upd_idx] <= r_ctr[w_upd_idx] - 2'b01;
            end
         end else if (i_upd_taken) begin
            r_valid[w_upd_idx]  <= 1'b1;
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= i_upd_target[31:2];
            r_ctr[w_upd_idx]    <= 2'b10;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mispred_cnt <= '0;
      end else if (o_mispredict && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
         r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor: one vector per cycle, checks sampled
// between the driving negedge and the next posedge, plus reset and same-cycle sequences.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] if_pc = '0;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid = 1'b0;
   logic [31:0] upd_pc = '0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_target = '0;
   logic        upd_pred_taken = 1'b0;
   logic [31:0] upd_pred_tgt = '0;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] mispred_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   branch_predictor #(.IDX_W(6), .TAG_W(24)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_if_pc          (if_pc),
      .o_pred_taken     (pred_taken),
      .o_pred_target    (pred_target),
      .i_upd_valid      (upd_valid),
      .i_upd_pc         (upd_pc),
      .i_upd_taken      (upd_taken),
      .i_upd_target     (upd_target),
      .i_upd_pred_taken (upd_pred_taken),
      .i_upd_pred_tgt   (upd_pred_tgt),
      .o_mispredict     (mispredict),
      .o_redirect_pc    (redirect_pc),
      .o_mispred_cnt    (mispred_cnt)
   );

   typedef struct {
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic [31:0] utgt;
      logic        upt;
      logic [31:0] uptgt;
      logic [31:0] ifpc;
      logic        e_pt;
      logic [31:0] e_ptgt;
      logic        e_mp;
      logic [31:0] e_redir;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t vecs [22];

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (vec %0d): got 0x%08h, expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      upd_valid      = v.uv;
      upd_pc         = v.upc;
      upd_taken      = v.ut;
      upd_target     = v.utgt;
      upd_pred_taken = v.upt;
      upd_pred_tgt   = v.uptgt;
      if_pc          = v.ifpc;
   endtask

   task automatic idle();
      upd_valid = 1'b0;
      upd_taken = 1'b0;
      upd_pred_taken = 1'b0;
   endtask

   function automatic vec_t mk(input logic uv, input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic upt,
                               input logic [31:0] uptgt, input logic [31:0] ifpc,
                               input logic e_pt, input logic [31:0] e_ptgt,
                               input logic e_mp, input logic [31:0] e_redir,
                               input logic [31:0] e_cnt);
      vec_t v;
      v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
      v.ifpc = ifpc; v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mp = e_mp;
      v.e_redir = e_redir; v.e_cnt = e_cnt;
      return v;
   endfunction

   initial begin
      // Fields: uv upc ut utgt upt uptgt | ifpc -> pred_taken pred_target mispredict redir cnt
      vecs[0]  = mk(0, 32'h100, 0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h0,   0);
      vecs[1]  = mk(1, 32'h100, 1, 32'h80,  0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80,  0);
      vecs[2]  = mk(1, 32'h100, 1, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  0, 32'h0,   1);
      vecs[3]  = mk(1, 32'h100, 1, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  0, 32'h0,   1);
      vecs[4]  = mk(1, 32'h100, 0, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  1, 32'h104, 1);
      vecs[5]  = mk(0, 32'h100, 0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h80,  0, 32'h0,   2);
      vecs[6]  = mk(1, 32'h100, 0, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  1, 32'h104, 2);
      vecs[7]  = mk(0, 32'h100, 0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h0,   3);
      vecs[8]  = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h0,   3);
      vecs[9]  = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h0,   3);
      vecs[10] = mk(1, 32'h100, 1, 32'h84,  0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h84,  3);
      vecs[11] = mk(1, 32'h100, 1, 32'h84,  0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h84,  4);
      vecs[12] = mk(0, 32'h100, 0, 32'h0,   0, 32'h0,   32'h100, 1, 32'h84,  0, 32'h0,   5);
      vecs[13] = mk(1, 32'h100, 1, 32'h90,  1, 32'h84,  32'h100, 1, 32'h84,  1, 32'h90,  5);
      vecs[14] = mk(1, 32'h200, 1, 32'h300, 0, 32'h204, 32'h200, 0, 32'h204, 1, 32'h300, 6);
      vecs[15] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h0,   7);
      vecs[16] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h200, 1, 32'h300, 0, 32'h0,   7);
      vecs[17] = mk(0, 32'h200, 1, 32'h500, 0, 32'h0,   32'h200, 1, 32'h300, 0, 32'h0,   7);
      vecs[18] = mk(1, 32'h400, 0, 32'h0,   0, 32'h0,   32'h400, 0, 32'h404, 0, 32'h0,   7);
      vecs[19] = mk(1, 32'h104, 1, 32'h500, 1, 32'h500, 32'h104, 0, 32'h108, 0, 32'h0,   7);
      vecs[20] = mk(1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h40, 32'hFFFF_FFFC,
                    0, 32'h0, 1, 32'h0, 7);
      vecs[21] = mk(0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h104, 1, 32'h500, 0, 32'h0,   8);

      // Reset state check while rst_n is asserted.
      if_pc = 32'h100;
      #2;
      check("reset_pred_taken", -1, {31'b0, pred_taken}, 32'h0);
      check("reset_pred_target", -1, pred_target, 32'h104);
      check("reset_cnt", -1, mispred_cnt, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #2;
         check("pred_taken", i, {31'b0, pred_taken}, {31'b0, vecs[i].e_pt});
         check("pred_target", i, pred_target, vecs[i].e_ptgt);
         check("mispredict", i, {31'b0, mispredict}, {31'b0, vecs[i].e_mp});
         if (vecs[i].e_mp) check("redirect_pc", i, redirect_pc, vecs[i].e_redir);
         check("mispred_cnt", i, mispred_cnt, vecs[i].e_cnt);
      end

      // Reset asserted with an update in flight across a clock edge: update must be lost.
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 32'h300; upd_taken = 1'b1; upd_target = 32'h700;
      upd_pred_taken = 1'b0; if_pc = 32'h300;
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_cnt", 100, mispred_cnt, 32'h0);
      @(negedge clk);
      idle();
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         if_pc = vecs[i].ifpc;
         #1;
         check("rst_miss_taken", 100 + i, {31'b0, pred_taken}, 32'h0);
         check("rst_miss_tgt", 100 + i, pred_target, vecs[i].ifpc + 32'd4);
      end
      if_pc = 32'h300;
      #1;
      check("rst_inflight_dropped", 200, {31'b0, pred_taken}, 32'h0);

      // Same-cycle update and lookup of an untrained PC: old contents that cycle, new next.
      @(negedge clk);
      upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_target = 32'h240;
      upd_pred_taken = 1'b0; if_pc = 32'h200;
      #2;
      check("rbw_same_cycle", 300, {31'b0, pred_taken}, 32'h0);
      check("rbw_same_tgt", 300, pred_target, 32'h204);
      check("rbw_mispredict", 300, {31'b0, mispredict}, 32'h1);
      @(negedge clk);
      idle();
      #2;
      check("rbw_next_cycle", 301, {31'b0, pred_taken}, 32'h1);
      check("rbw_next_tgt", 301, pred_target, 32'h240);
      check("rbw_cnt", 301, mispred_cnt, 32'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
